string_process_match_mc: RTL and testbench

- Multi-core successor of the single-core string matcher.
- Assembles a sliding window of the last proc_str_len bits of the byte stream into padded MD5 blocks and dispatches one block per incoming byte, round-robin over NUM_CORES MD5 cores.
- Checks every returned hash against the target and reports the lowest matching byte position, its string and the match count.
- Sits between the cmd_parser and an array of NUM_CORES identical fixed-latency MD5 cores.

---
 rtl/string_process_match_mc.sv | 159 +++++++++++++++
 tb/tb_string_process_match_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_process_match_mc.sv
// rtl/string_process_match_mc.sv - sliding-window MD5 block builder with round-robin dispatch and lowest-position match check
// Optional macro STRING_PROCESS_MATCH_COUNT_EN adds the saturating proc_match_count output.
module string_process_match_mc #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     proc_start,
  input  logic [7:0]               proc_data,
  input  logic                     proc_data_valid,
  input  logic                     proc_last,
  input  logic                     proc_match_char_next,
  input  logic [127:0]             proc_target_hash,
  input  logic [15:0]              proc_str_len,
  output logic                     proc_done,
  output logic                     proc_match,
  output logic [CNT_W-1:0]         proc_byte_pos,
  output logic [7:0]               proc_match_char,
  output logic                     proc_busy,
  output logic                     proc_ready,
  output logic [447:0]             md5_msg,
  output logic [15:0]              md5_length,
  output logic [NUM_CORES-1:0]     md5_msg_valid,
  input  logic [NUM_CORES*128-1:0] hash_ret,
  input  logic [NUM_CORES*512-1:0] msg_ret,
  input  logic [NUM_CORES-1:0]     hash_ret_valid
`ifdef STRING_PROCESS_MATCH_COUNT_EN
  ,
  output logic [15:0]              proc_match_count
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt [NUM_CORES];
  logic [CNT_W-1:0] byte_count_in;
  logic [CNT_W-1:0] byte_count_out;
  logic             dma_done;
  logic [511:0]     match_msg;

  logic [447:0]     msg_next;
  logic [15:0]      shamt;
  logic [8:0]       pad_bit;

  assign shamt   = 16'd440 - proc_str_len;
  assign pad_bit = 9'd455 - proc_str_len[8:0];

  // New byte lands just above the 0x80 pad; the old pad bit under it is overwritten by the data MSB.
  always_comb begin
    msg_next          = (md5_msg << 8) | ({432'd0, proc_data, 8'h80} << shamt);
    msg_next[pad_bit] = proc_data[7];
  end

  logic [NUM_CORES-1:0] hit;
  logic [CNT_W-1:0]     cur_pos;
  logic                 any_hit;
  logic [CNT_W-1:0]     best_pos;
  logic [511:0]         best_msg;
  logic [CNT_W-1:0]     ret_cnt;
  logic                 store;

  always_comb begin
    hit      = '0;
    cur_pos  = '0;
    any_hit  = 1'b0;
    best_pos = '0;
    best_msg = '0;
    ret_cnt  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cur_pos = cnt[i] * CNT_W'(NUM_CORES) + CNT_W'(i);
      hit[i]  = hash_ret_valid[i] && (hash_ret[128*i +: 128] == proc_target_hash);
      ret_cnt = ret_cnt + CNT_W'(hash_ret_valid[i]);
      if (hit[i] && (!any_hit || cur_pos < best_pos)) begin
        any_hit  = 1'b1;
        best_pos = cur_pos;
        best_msg = msg_ret[512*i +: 512];
      end
    end
  end

  assign store           = any_hit && (!proc_match || best_pos < proc_byte_pos);
  assign proc_match_char = match_msg[511:504];
  assign proc_ready      = proc_busy;

`ifdef STRING_PROCESS_MATCH_COUNT_EN
  logic [4:0]  hit_cnt;
  logic [16:0] count_sum;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) hit_cnt = hit_cnt + 5'(hit[i]);
    count_sum = {1'b0, proc_match_count} + 17'(hit_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           proc_match_count <= '0;
    else if (proc_start) proc_match_count <= '0;
    else                 proc_match_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      byte_count_in  <= '0;
      byte_count_out <= '0;
      dma_done       <= 1'b0;
      match_msg      <= '0;
      proc_done      <= 1'b0;
      proc_match     <= 1'b0;
      proc_byte_pos  <= '0;
      proc_busy      <= 1'b0;
      md5_msg        <= '0;
      md5_length     <= '0;
      md5_msg_valid  <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt[i] <= '0;
    end else if (proc_start) begin
      ptr            <= '0;
      byte_count_in  <= '0;
      byte_count_out <= '0;
      dma_done       <= 1'b0;
      match_msg      <= '0;
      proc_done      <= 1'b0;
      proc_match     <= 1'b0;
      proc_byte_pos  <= '0;
      proc_busy      <= 1'b1;
      md5_msg_valid  <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt[i] <= '0;
    end else begin
      if (proc_data_valid) begin
        md5_msg       <= msg_next;
        md5_length    <= proc_str_len;
        md5_msg_valid <= NUM_CORES'(1) << ptr;
        ptr           <= (ptr == PTR_W'(NUM_CORES - 1)) ? '0 : ptr + 1'b1;
        byte_count_in <= byte_count_in + CNT_W'(1);
      end else begin
        md5_msg_valid <= '0;
      end
      byte_count_out <= byte_count_out + ret_cnt;
      for (int i = 0; i < NUM_CORES; i++)
        if (hash_ret_valid[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      if (store) begin
        proc_match    <= 1'b1;
        proc_byte_pos <= best_pos;
        match_msg     <= best_msg;
      end else if (proc_match_char_next) begin
        match_msg <= match_msg << 8;
      end
      if (proc_last) dma_done <= 1'b1;
      if (dma_done && byte_count_in == byte_count_out) begin
        proc_done <= 1'b1;
        proc_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_string_process_match_mc.sv
// tb/tb_string_process_match_mc.sv - directed bench with loopback/manual MD5 core models
module tb_string_process_match_mc;
  localparam int NC = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            proc_start, proc_data_valid, proc_last, proc_match_char_next;
  logic [7:0]      proc_data;
  logic [127:0]    proc_target_hash;
  logic [15:0]     proc_str_len;
  logic            proc_done, proc_match, proc_busy, proc_ready;
  logic [CW-1:0]   proc_byte_pos;
  logic [7:0]      proc_match_char;
  logic [447:0]    md5_msg;
  logic [15:0]     md5_length;
  logic [NC-1:0]   md5_msg_valid;
  logic [NC*128-1:0] hash_ret;
  logic [NC*512-1:0] msg_ret;
  logic [NC-1:0]   hash_ret_valid;
`ifdef STRING_PROCESS_MATCH_COUNT_EN
  logic [15:0]     proc_match_count;
`endif

  string_process_match_mc #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .proc_start(proc_start), .proc_data(proc_data),
    .proc_data_valid(proc_data_valid), .proc_last(proc_last),
    .proc_match_char_next(proc_match_char_next), .proc_target_hash(proc_target_hash),
    .proc_str_len(proc_str_len), .proc_done(proc_done), .proc_match(proc_match),
    .proc_byte_pos(proc_byte_pos), .proc_match_char(proc_match_char), .proc_busy(proc_busy),
    .proc_ready(proc_ready), .md5_msg(md5_msg), .md5_length(md5_length),
    .md5_msg_valid(md5_msg_valid), .hash_ret(hash_ret), .msg_ret(msg_ret),
    .hash_ret_valid(hash_ret_valid)
`ifdef STRING_PROCESS_MATCH_COUNT_EN
    , .proc_match_count(proc_match_count)
`endif
  );

  function automatic logic [127:0] fh(input logic [447:0] m);
    return m[447:320] ^ m[319:192] ^ m[191:64] ^ {m[63:0], 64'h0};
  endfunction

  // Loopback cores: fixed latency 3, hash is a cheap fold of the message.
  logic          loop_mode = 1'b0;
  logic [NC-1:0] lb_v1 = '0, lb_v2 = '0, lb_v3 = '0;
  logic [447:0]  lb_m1 = '0, lb_m2 = '0, lb_m3 = '0;
  logic [15:0]   lb_l1 = '0, lb_l2 = '0, lb_l3 = '0;
  logic [NC-1:0] man_v = '0;
  logic [127:0]  man_h [NC];
  logic [511:0]  man_m [NC];
  int            ret_total = 0;

  always @(posedge clk) begin
    lb_v1 <= md5_msg_valid; lb_m1 <= md5_msg; lb_l1 <= md5_length;
    lb_v2 <= lb_v1;         lb_m2 <= lb_m1;   lb_l2 <= lb_l1;
    lb_v3 <= lb_v2;         lb_m3 <= lb_m2;   lb_l3 <= lb_l2;
    ret_total <= ret_total + $countones(hash_ret_valid);
  end

  always_comb begin
    hash_ret = '0;
    msg_ret  = '0;
    for (int i = 0; i < NC; i++) begin
      hash_ret[128*i +: 128] = loop_mode ? fh(lb_m3) : man_h[i];
      msg_ret[512*i +: 512]  = loop_mode ? {lb_m3, 48'd0, lb_l3} : man_m[i];
    end
    hash_ret_valid = loop_mode ? lb_v3 : man_v;
  end

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] TGT = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] NOH = 128'h1;
  localparam logic [511:0] M12 = {8'hC1, 8'hC2, 496'd0};
  localparam logic [511:0] M9  = {8'h91, 8'h92, 496'd0};
  localparam logic [511:0] M11 = {8'hB1, 8'hB2, 496'd0};
  localparam logic [511:0] M16 = {8'hE1, 8'hE2, 496'd0};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    proc_start = 0; proc_data_valid = 0; proc_last = 0; proc_match_char_next = 0;
    proc_data = 0; man_v = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1; tick(); tick(); reset = 0; tick();
  endtask

  task automatic start_batch();
    proc_start = 1; tick(); proc_start = 0;
  endtask

  task automatic one_ret(input int c, input logic [127:0] h, input logic [511:0] m);
    man_h[c] = h; man_m[c] = m; man_v = NC'(1) << c;
    tick();
    man_v = '0;
  endtask

  task automatic send_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      proc_data = 8'h30 + 8'(k); proc_data_valid = 1; proc_last = (k == n - 1);
      tick();
    end
    proc_data_valid = 0; proc_last = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    proc_str_len = 16'd152; proc_target_hash = TGT;
    reset = 1; #2;
    total++; if (proc_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", proc_busy); end
    total++; if (proc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", proc_ready); end
    total++; if (proc_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", proc_done); end
    total++; if (proc_match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", proc_match); end
    total++; if (proc_byte_pos !== '0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", proc_byte_pos); end
    total++; if (proc_match_char !== 8'h00) begin bad++; $display("FAIL reset_char got=%h exp=00", proc_match_char); end
    total++; if (md5_msg_valid !== '0) begin bad++; $display("FAIL reset_strobe got=%b exp=0000", md5_msg_valid); end
    total++; if (md5_msg !== '0) begin bad++; $display("FAIL reset_msg got=%h exp=0", md5_msg); end
    total++; if (md5_length !== 16'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", md5_length); end
    tick(); reset = 0; tick();
  endtask

  task automatic test_stream();
    logic [7:0]   b [40];
    logic [447:0] em;
    int           base;
    do_reset();
    loop_mode = 1; proc_str_len = 16'd152;
    for (int k = 0; k < 40; k++) b[k] = 8'h41 + 8'(k);
    em = '0;
    for (int j = 0; j < 19; j++) em[447-8*j -: 8] = b[4+j];
    em[295:288] = 8'h80;
    proc_target_hash = fh(em);
    base = ret_total;
    start_batch();
    total++; if (proc_busy !== 1'b1 || proc_ready !== 1'b1) begin bad++; $display("FAIL start_busy got=%b/%b exp=1/1", proc_busy, proc_ready); end
    for (int k = 0; k < 40; k++) begin
      proc_data = b[k]; proc_data_valid = 1; proc_last = (k == 39);
      tick();
      total++; if (md5_msg_valid !== (NC'(1) << (k % NC))) begin bad++; $display("FAIL strobe_%0d got=%b exp=%b", k, md5_msg_valid, NC'(1) << (k % NC)); end
      if (k == 22) begin
        total++; if (md5_msg !== em) begin bad++; $display("FAIL msg_22 got=%h exp=%h", md5_msg, em); end
        total++; if (md5_length !== 16'd152) begin bad++; $display("FAIL len_22 got=%0d exp=152", md5_length); end
      end
    end
    proc_data_valid = 0; proc_last = 0;
    tick();
    total++; if (md5_msg_valid !== '0) begin bad++; $display("FAIL strobe_idle got=%b exp=0000", md5_msg_valid); end
    for (int c = 0; c < 60 && (ret_total - base) < 40; c++) tick();
    total++; if (ret_total - base != 40) begin bad++; $display("FAIL ret_timeout got=%0d exp=40", ret_total - base); end
    total++; if (proc_done !== 1'b0) begin bad++; $display("FAIL done_at_last_ret got=%b exp=0", proc_done); end
    tick();
    total++; if (proc_done !== 1'b1) begin bad++; $display("FAIL done_after got=%b exp=1", proc_done); end
    total++; if (proc_busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%b exp=0", proc_busy); end
    total++; if (proc_match !== 1'b1) begin bad++; $display("FAIL stream_match got=%b exp=1", proc_match); end
    total++; if (proc_byte_pos !== 32'd22) begin bad++; $display("FAIL stream_pos got=%0d exp=22", proc_byte_pos); end
    for (int j = 0; j < 19; j++) begin
      total++; if (proc_match_char !== b[4+j]) begin bad++; $display("FAIL char_%0d got=%h exp=%h", j, proc_match_char, b[4+j]); end
      proc_match_char_next = 1; tick(); proc_match_char_next = 0;
    end
    total++; if (proc_match_char !== 8'h80) begin bad++; $display("FAIL char_pad got=%h exp=80", proc_match_char); end
    loop_mode = 0;
  endtask

  task automatic test_simul_match();
    do_reset();
    proc_target_hash = TGT;
    start_batch();
    for (int r = 0; r < 3; r++) one_ret(0, NOH, '0);
    one_ret(0, TGT, M12);
    total++; if (proc_match !== 1'b1 || proc_byte_pos !== 32'd12) begin bad++; $display("FAIL first_store got=%b/%0d exp=1/12", proc_match, proc_byte_pos); end
    total++; if (proc_match_char !== 8'hC1) begin bad++; $display("FAIL first_char got=%h exp=c1", proc_match_char); end
    man_h[1] = NOH; man_h[3] = NOH; man_v = 4'b1010; tick(); tick(); man_v = '0;
    man_h[1] = TGT; man_m[1] = M9; man_h[3] = TGT; man_m[3] = M11;
    man_v = 4'b1010; proc_match_char_next = 1; tick(); man_v = '0; proc_match_char_next = 0;
    total++; if (proc_byte_pos !== 32'd9) begin bad++; $display("FAIL lowest_pos got=%0d exp=9", proc_byte_pos); end
    total++; if (proc_match_char !== 8'h91) begin bad++; $display("FAIL store_over_shift got=%h exp=91", proc_match_char); end
    one_ret(0, TGT, M16);
    total++; if (proc_byte_pos !== 32'd9 || proc_match_char !== 8'h91) begin bad++; $display("FAIL later_ignored got=%0d/%h exp=9/91", proc_byte_pos, proc_match_char); end
    proc_match_char_next = 1; tick(); proc_match_char_next = 0;
    total++; if (proc_match_char !== 8'h92) begin bad++; $display("FAIL shift_char got=%h exp=92", proc_match_char); end
`ifdef STRING_PROCESS_MATCH_COUNT_EN
    total++; if (proc_match_count !== 16'd4) begin bad++; $display("FAIL match_count got=%0d exp=4", proc_match_count); end
`endif
  endtask

  task automatic test_outstanding();
    do_reset();
    proc_target_hash = TGT; proc_str_len = 16'd152;
    start_batch();
    send_bytes(3);
    one_ret(0, NOH, '0);
    tick(); tick(); tick();
    total++; if (proc_done !== 1'b0) begin bad++; $display("FAIL done_two_out got=%b exp=0", proc_done); end
    one_ret(1, NOH, '0);
    tick(); tick();
    total++; if (proc_done !== 1'b0 || proc_busy !== 1'b1) begin bad++; $display("FAIL done_one_out got=%b/%b exp=0/1", proc_done, proc_busy); end
    one_ret(2, NOH, '0);
    tick();
    total++; if (proc_done !== 1'b1 || proc_busy !== 1'b0) begin bad++; $display("FAIL done_all_in got=%b/%b exp=1/0", proc_done, proc_busy); end
    tick();
    total++; if (proc_done !== 1'b1) begin bad++; $display("FAIL done_hold got=%b exp=1", proc_done); end
    start_batch();
    send_bytes(1);
    one_ret(0, TGT, M12);
    total++; if (proc_match !== 1'b1) begin bad++; $display("FAIL pre_restart_match got=%b exp=1", proc_match); end
    proc_start = 1; proc_data_valid = 1; proc_data = 8'h55; proc_last = 1; proc_match_char_next = 1;
    man_h[1] = TGT; man_m[1] = M9; man_v = 4'b0010;
    tick();
    clear_inputs();
    total++; if (proc_busy !== 1'b1 || proc_ready !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b/%b exp=1/1", proc_busy, proc_ready); end
    total++; if (proc_match !== 1'b0 || proc_byte_pos !== '0) begin bad++; $display("FAIL restart_match got=%b/%0d exp=0/0", proc_match, proc_byte_pos); end
    total++; if (proc_done !== 1'b0 || proc_match_char !== 8'h00) begin bad++; $display("FAIL restart_done_char got=%b/%h exp=0/00", proc_done, proc_match_char); end
    total++; if (md5_msg_valid !== '0) begin bad++; $display("FAIL restart_strobe got=%b exp=0000", md5_msg_valid); end
    tick();
    total++; if (proc_done !== 1'b0) begin bad++; $display("FAIL restart_last_ignored got=%b exp=0", proc_done); end
  endtask

  task automatic test_async_reset();
    logic [15:0] head;
    do_reset();
    proc_target_hash = TGT; proc_str_len = 16'd152;
    start_batch();
    send_bytes(2);
    one_ret(0, TGT, M12);
    total++; if (proc_busy !== 1'b1 || proc_match !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b/%b exp=1/1", proc_busy, proc_match); end
    @(posedge clk); #3;
    reset = 1; #1;
    total++; if (proc_busy !== 1'b0 || proc_ready !== 1'b0) begin bad++; $display("FAIL async_busy got=%b/%b exp=0/0", proc_busy, proc_ready); end
    total++; if (proc_match !== 1'b0 || proc_byte_pos !== '0 || proc_match_char !== 8'h00) begin bad++; $display("FAIL async_match got=%b/%0d/%h exp=0/0/00", proc_match, proc_byte_pos, proc_match_char); end
    total++; if (md5_msg !== '0 || md5_length !== 16'd0 || md5_msg_valid !== '0) begin bad++; $display("FAIL async_msg got=%0d/%b exp=0/0000", md5_length, md5_msg_valid); end
    @(posedge clk); #1; reset = 0;
    proc_str_len = 16'd8; proc_data = 8'h61; proc_data_valid = 1;
    tick();
    proc_data_valid = 0;
    head = md5_msg[447:432];
    total++; if (head !== 16'h6180) begin bad++; $display("FAIL len8_msg got=%h exp=6180", head); end
    total++; if (md5_length !== 16'd8) begin bad++; $display("FAIL len8_len got=%0d exp=8", md5_length); end
    total++; if (md5_msg_valid !== 4'b0001) begin bad++; $display("FAIL len8_strobe got=%b exp=0001", md5_msg_valid); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NC; i++) begin man_h[i] = '0; man_m[i] = '0; end
    test_reset();
    test_stream();
    test_simul_match();
    test_outstanding();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
